// File: rtl/i2c_frame_decoder_if.sv
// Bus bundle for the passive I2C frame decoder: filtered SCL/SDA line levels
// in, per-byte reports and framing pulses out.
// Optional build macro: I2C_ADDR_MATCH_EN adds the addr_match report.
interface i2c_frame_decoder_if #(
  parameter int BYTE_CNT_W = 8
);
  logic                  scl;
  logic                  sda;
  logic                  start;
  logic                  stop;
  logic [7:0]            data;
  logic                  data_valid;
  logic                  ack;
  logic                  is_addr;
  logic [BYTE_CNT_W-1:0] byte_idx;
  logic                  busy;
  logic                  err;
`ifdef I2C_ADDR_MATCH_EN
  logic                  addr_match;
`endif

  // Bus side: drives the line levels, observes the reports.
  modport master (
    output scl, sda,
    input  start, stop, data, data_valid, ack, is_addr, byte_idx, busy, err
`ifdef I2C_ADDR_MATCH_EN
    , input addr_match
`endif
  );

  // Decoder side: consumes the line levels, produces the reports.
  modport slave (
    input  scl, sda,
    output start, stop, data, data_valid, ack, is_addr, byte_idx, busy, err
`ifdef I2C_ADDR_MATCH_EN
    , output addr_match
`endif
  );
endinterface

// File: rtl/i2c_frame_decoder.sv
// Passive I2C frame decoder. Watches filtered SCL/SDA, detects START,
// repeated START and STOP, shifts bytes in MSB-first on SCL rising edges and
// reports data, ACK bit, byte position and framing errors. Never drives the bus.
// Event pulses appear two clocks after the line change is first sampled.
// Optional build macro: I2C_ADDR_MATCH_EN (adds SLAVE_ADDR and addr_match).
module i2c_frame_decoder #(
  parameter int BYTE_CNT_W = 8
`ifdef I2C_ADDR_MATCH_EN
  , parameter logic [6:0] SLAVE_ADDR = 7'h50
`endif
) (
  input logic               clk,
  input logic               rst,
  i2c_frame_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DATA, ACKB} state_t;

  // Two-stage line sampling (s = newest, p = previous).
  logic s_scl, s_sda, p_scl, p_sda;

  // Registered bus events decoded from s vs p.
  logic ev_start, ev_stop, ev_rise, ev_bit;

  // FSM state and frame bookkeeping.
  state_t                state, state_d;
  logic [2:0]            bitcnt, bitcnt_d;
  logic [7:0]            shift, shift_d;
  logic [BYTE_CNT_W-1:0] idx, idx_d;
  logic                  first, first_d;

  // Registered outputs.
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  dv_q, dv_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic [7:0]            data_q, data_d;
  logic                  ack_q, ack_d;
  logic                  is_addr_q, is_addr_d;
  logic [BYTE_CNT_W-1:0] byte_idx_q, byte_idx_d;
  logic                  am_q, am_d;

  // Line sampling stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: stage registers reset to 1 (idle bus) so leaving reset on an idle bus cannot look like a START.
      s_scl <= 1'b1;
      s_sda <= 1'b1;
      p_scl <= 1'b1;
      p_sda <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value; blocking here would collapse s and p into one stage.
      s_scl <= bus.scl;
      s_sda <= bus.sda;
      p_scl <= s_scl;
      p_sda <= s_sda;
    end
  end

  // Event decode; START/STOP need SCL stable high, so they never coincide with a rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      ev_rise  <= 1'b0;
      ev_bit   <= 1'b0;
    end else begin
      ev_start <= p_scl & s_scl & p_sda & ~s_sda;
      ev_stop  <= p_scl & s_scl & ~p_sda & s_sda;
      ev_rise  <= ~p_scl & s_scl;
      ev_bit   <= s_sda;
    end
  end

  // FSM state, bookkeeping and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shift      <= '0;
      idx        <= '0;
      first      <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      is_addr_q  <= 1'b0;
      byte_idx_q <= '0;
      am_q       <= 1'b0;
    end else begin
      state      <= state_d;
      bitcnt     <= bitcnt_d;
      shift      <= shift_d;
      idx        <= idx_d;
      first      <= first_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      is_addr_q  <= is_addr_d;
      byte_idx_q <= byte_idx_d;
      am_q       <= am_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned, which would infer a latch.
    state_d    = state;
    bitcnt_d   = bitcnt;
    shift_d    = shift;
    idx_d      = idx;
    first_d    = first;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    busy_d     = busy_q;
    data_d     = data_q;
    ack_d      = ack_q;
    is_addr_d  = is_addr_q;
    byte_idx_d = byte_idx_q;
    am_d       = am_q;

    unique case (state)
      IDLE: begin
        // Clock edges and STOPs on an idle bus are not ours to report.
        if (ev_start) begin
          state_d  = DATA;
          bitcnt_d = '0;
          idx_d    = '0;
          first_d  = 1'b1;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          am_d     = 1'b0;
        end
      end

      DATA, ACKB: begin
        if (ev_start) begin
          // Repeated START: restart the frame; a partial byte is a framing error.
          start_d  = 1'b1;
          err_d    = (bitcnt != 3'd0) || (state == ACKB);
          state_d  = DATA;
          bitcnt_d = '0;
          idx_d    = '0;
          first_d  = 1'b1;
          am_d     = 1'b0;
        end else if (ev_stop) begin
          stop_d   = 1'b1;
          err_d    = (bitcnt != 3'd0) || (state == ACKB);
          busy_d   = 1'b0;
          state_d  = IDLE;
          bitcnt_d = '0;
          am_d     = 1'b0;
        end else if (ev_rise) begin
          if (state == DATA) begin
            shift_d  = {shift[6:0], ev_bit};
            // 3-bit counter wraps to 0 on the 8th bit, ready for the next byte.
            bitcnt_d = bitcnt + 3'd1;
            if (bitcnt == 3'd7) state_d = ACKB;
          end else begin
            data_d     = shift;
            ack_d      = ev_bit;
            is_addr_d  = first;
            byte_idx_d = idx;
            dv_d       = 1'b1;
`ifdef I2C_ADDR_MATCH_EN
            am_d       = first && (shift[7:1] == SLAVE_ADDR);
`endif
            first_d    = 1'b0;
            idx_d      = (idx == '1) ? idx : idx + 1'b1;
            bitcnt_d   = '0;
            state_d    = DATA;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.start      = start_q;
  assign bus.stop       = stop_q;
  assign bus.data_valid = dv_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.data       = data_q;
  assign bus.ack        = ack_q;
  assign bus.is_addr    = is_addr_q;
  assign bus.byte_idx   = byte_idx_q;
`ifdef I2C_ADDR_MATCH_EN
  assign bus.addr_match = am_q;
`endif

endmodule

// File: tb/tb_i2c_frame_decoder.sv
// Testbench for i2c_frame_decoder: directed bus sequences push expected
// reports into a queue; a monitor pops and compares on every reported pulse.
// Optional build macro: I2C_ADDR_MATCH_EN enables the address-match frames.
module tb_i2c_frame_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_frame_decoder_if #(.BYTE_CNT_W(8)) bus ();
  i2c_frame_decoder #(.BYTE_CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       st, sp, dv, er, bz;
    logic [7:0] d;
    logic       a, ia;
    logic [7:0] idx;
    logic       am;
  } ev_t;

  ev_t exp_q[$];
  ev_t got, want;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void exp_ev(logic st, sp, dv, er, bz, logic [7:0] d,
                                 logic a, ia, logic [7:0] idx, logic am);
    ev_t e;
    e = {st, sp, dv, er, bz, d, a, ia, idx, am};
    exp_q.push_back(e);
  endfunction

  function automatic void exp_start(logic er);
    exp_ev(1, 0, 0, er, 1, 8'h00, 0, 0, 8'h00, 0);
  endfunction

  function automatic void exp_stop(logic er);
    exp_ev(0, 1, 0, er, 0, 8'h00, 0, 0, 8'h00, 0);
  endfunction

  function automatic void exp_dv(logic [7:0] d, logic a, ia, logic [7:0] idx, logic am);
    exp_ev(0, 0, 1, 0, 1, d, a, ia, idx, am);
  endfunction

  // Monitor: every reported pulse must match the next expected record.
  always @(negedge clk) begin
    if (bus.start || bus.stop || bus.data_valid || bus.err) begin
`ifdef I2C_ADDR_MATCH_EN
      got = {bus.start, bus.stop, bus.data_valid, bus.err, bus.busy, bus.data,
             bus.ack, bus.is_addr, bus.byte_idx, bus.addr_match};
`else
      got = {bus.start, bus.stop, bus.data_valid, bus.err, bus.busy, bus.data,
             bus.ack, bus.is_addr, bus.byte_idx, 1'b0};
`endif
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h with no report expected", got);
      end else begin
        want = exp_q.pop_front();
        if (!want.dv) begin
          got.d   = '0;
          got.a   = 1'b0;
          got.ia  = 1'b0;
          got.idx = '0;
        end
        if (got !== want) begin
          n_fail++;
          $display("FAIL report: got st=%b sp=%b dv=%b er=%b bz=%b d=%h a=%b ia=%b idx=%0d am=%b required st=%b sp=%b dv=%b er=%b bz=%b d=%h a=%b ia=%b idx=%0d am=%b",
                   got.st, got.sp, got.dv, got.er, got.bz, got.d, got.a, got.ia, got.idx, got.am,
                   want.st, want.sp, want.dv, want.er, want.bz, want.d, want.a, want.ia, want.idx, want.am);
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One bus half-phase.
  task automatic hp();
    repeat (4) @(negedge clk);
  endtask

  // START (or repeated START when SCL is low; its SCL rise is seen as a data bit).
  task automatic bus_start();
    bus.sda = 1'b1; hp();
    bus.scl = 1'b1; hp();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b0; hp();
  endtask

  task automatic send_bit(logic b);
    bus.sda = b;    hp();
    bus.scl = 1'b1; hp();
    bus.scl = 1'b0; hp();
  endtask

  task automatic send_byte(logic [7:0] d, logic a);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(a);
  endtask

  // STOP from SCL low: its own SCL rise is decoded as one more data bit.
  task automatic stop_raw();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b1; hp();
    bus.sda = 1'b1; hp();
  endtask

  // SCL rise with SDA=0 (ACK) held high, then SDA release: STOP with no extra bit.
  task automatic ack0_stop();
    bus.sda = 1'b0; hp();
    bus.scl = 1'b1; hp();
    bus.sda = 1'b1; hp();
  endtask

  task automatic send_byte_stop(logic [7:0] d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    ack0_stop();
  endtask

  initial begin
    bus.scl = 1'b1;
    bus.sda = 1'b1;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.start, bus.stop, bus.data, bus.data_valid, bus.ack, bus.is_addr,
           bus.byte_idx, bus.busy, bus.err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // START latency: pulse exactly two clocks after the sampling edge.
    exp_start(1'b0);
    bus.sda = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 check("start_not_early", bus.start, 1'b0);
    @(posedge clk); #1 check("start_pulse", bus.start, 1'b1);
    check("busy_after_start", bus.busy, 1'b1);
    check("err_at_start", bus.err, 1'b0);
    @(posedge clk); #1 check("start_one_cycle", bus.start, 1'b0);
    hp();
    bus.scl = 1'b0;
    hp();

    // Two-byte frame; STOP from SCL low adds one bit, so it is flagged.
    exp_dv(8'hA0, 1'b0, 1'b1, 8'd0, 1'b0);
    send_byte(8'hA0, 1'b0);
    exp_dv(8'h5C, 1'b1, 1'b0, 8'd1, 1'b0);
    send_byte(8'h5C, 1'b1);
    exp_stop(1'b1);
    stop_raw();
    hp();
    check("busy_after_stop", bus.busy, 1'b0);
    check("data_holds", bus.data, 8'h5C);

    // Clean frame ending ACK-held-high then STOP: no error.
    exp_start(1'b0);
    bus_start();
    exp_dv(8'h12, 1'b0, 1'b1, 8'd0, 1'b0);
    exp_stop(1'b0);
    send_byte_stop(8'h12);

    // Repeated START mid-byte: start+err together, partial byte dropped.
    exp_start(1'b0);
    bus_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    exp_start(1'b1);
    bus_start();
    exp_dv(8'h91, 1'b0, 1'b1, 8'd0, 1'b0);
    exp_stop(1'b0);
    send_byte_stop(8'h91);

    // STOP after 8 bits (last bit carried by the STOP's SCL rise), before the 9th rise.
    exp_start(1'b0);
    bus_start();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    exp_stop(1'b1);
    ack0_stop();
    hp();
    check("busy_after_err_stop", bus.busy, 1'b0);

    // Idle bus: SCL pulses, SDA toggles only while SCL low -> nothing reported.
    for (int i = 0; i < 20; i++) begin
      bus.scl = 1'b0;      hp();
      bus.sda = ~bus.sda;  hp();
      bus.scl = 1'b1;      hp();
    end
    check("idle_busy", bus.busy, 1'b0);

    // Reset mid-byte: outputs clear immediately; next frame decodes from scratch.
    exp_start(1'b0);
    bus_start();
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    check("busy_before_reset", bus.busy, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("outputs_in_reset",
             {bus.start, bus.stop, bus.data, bus.data_valid, bus.ack, bus.is_addr,
              bus.byte_idx, bus.busy, bus.err}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hp();
    exp_start(1'b0);
    bus_start();
    exp_dv(8'h3C, 1'b0, 1'b1, 8'd0, 1'b0);
    exp_stop(1'b0);
    send_byte_stop(8'h3C);

`ifdef I2C_ADDR_MATCH_EN
    // Address 0xA1 matches 7'h50; cleared again by STOP.
    exp_start(1'b0);
    bus_start();
    exp_dv(8'hA1, 1'b0, 1'b1, 8'd0, 1'b1);
    exp_stop(1'b0);
    send_byte_stop(8'hA1);
    hp();
    check("addr_match_cleared", bus.addr_match, 1'b0);
    // Address 0xA2 does not match.
    exp_start(1'b0);
    bus_start();
    exp_dv(8'hA2, 1'b0, 1'b1, 8'd0, 1'b0);
    exp_stop(1'b0);
    send_byte_stop(8'hA2);
`endif

    repeat (20) @(negedge clk);
    check("all_reports_seen", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
